// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : DEPTH x DATA_W RAM with MAR/MDR, streamed boot preload and
//            wait-stated single-word accesses with busy/done/err handshake.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 20,
    parameter int WAIT_CYCLES = 1,
    parameter int BOOT_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    output logic              boot_done,
    input  logic              ld_mar,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic              ld_mdr_data,
    input  logic [DATA_W-1:0] mdr_in,
    input  logic              rd_mem,
    input  logic              wr_mem,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_PTR_W = ADDR_W + 1;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [3:0]         c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mar;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_boot_done;
    logic                r_is_wr;
    logic [c_PTR_W-1:0]  r_boot_ptr;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_in_range;
    logic                w_boot_wr;
    logic                w_commit;
    logic                w_acc_wr;
    logic                w_we;
    logic [c_IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
    assign w_boot_wr  = (r_state == S_BOOT) && boot_valid;
    assign w_commit   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_acc_wr   = w_commit && r_is_wr && w_in_range;
    assign w_rd_data  = w_in_range ? r_mem[r_addr[c_IDX_W-1:0]] : '0;

    // Single RAM write port shared by boot preload and committed writes;
    // gating with reset makes a reset on the commit edge abort the write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_boot_ptr[c_IDX_W-1:0];
        w_wdata = boot_data;
        if (w_boot_wr) begin
            w_we = !reset;
        end else if (w_acc_wr) begin
            w_we    = !reset;
            w_waddr = r_addr[c_IDX_W-1:0];
            w_wdata = r_mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= (BOOT_EN != 0) ? S_BOOT : S_IDLE;
            r_boot_done <= (BOOT_EN == 0);
            r_mar       <= '0;
            r_addr      <= '0;
            r_mdr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_is_wr     <= 1'b0;
            r_boot_ptr  <= '0;
            r_cnt       <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    if (w_boot_wr) begin
                        r_boot_ptr <= r_boot_ptr + 1'b1;
                        if (r_boot_ptr == c_LAST) begin
                            r_boot_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (ld_mar) begin
                        r_mar <= mar_in;
                    end
                    if (ld_mdr_data) begin
                        r_mdr <= mdr_in;
                    end
                    if (rd_mem && wr_mem) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end else if (rd_mem || wr_mem) begin
                        r_state <= S_ACCESS;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_WAIT;
                        r_is_wr <= wr_mem;
                        r_addr  <= ld_mar ? mar_in : r_mar;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= !w_in_range;
                        if (!r_is_wr) begin
                            r_mdr <= w_rd_data;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign boot_done = r_boot_done;
    assign mar_out   = r_mar;
    assign mdr_out   = r_mdr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench: four parameter variants of mem_access_unit,
//            table vectors, hand-written corner sequences and random accesses.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    localparam int NI    = 4;
    localparam int DEPTH = 20;

    function automatic int wc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    function automatic int be_of(input int k);
        return (k == 0 || k == 2) ? 1 : 0;
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NI];
    logic        bv    [NI];
    logic        ldm   [NI];
    logic        ldd   [NI];
    logic        rd    [NI];
    logic        wr    [NI];
    logic [15:0] bd    [NI];
    logic [15:0] mdin  [NI];
    logic [4:0]  mar_i [NI];
    logic [4:0]  mar_o [NI];
    logic [15:0] mdr_o [NI];
    logic        bdone [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        err   [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int c_WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
            localparam int c_BE = (g == 0 || g == 2) ? 1 : 0;
            mem_access_unit #(
                .DATA_W(16), .ADDR_W(5), .DEPTH(DEPTH),
                .WAIT_CYCLES(c_WC), .BOOT_EN(c_BE)
            ) u_dut (
                .clk(clk), .reset(rst[g]),
                .boot_valid(bv[g]), .boot_data(bd[g]), .boot_done(bdone[g]),
                .ld_mar(ldm[g]), .mar_in(mar_i[g]),
                .ld_mdr_data(ldd[g]), .mdr_in(mdin[g]),
                .rd_mem(rd[g]), .wr_mem(wr[g]),
                .mar_out(mar_o[g]), .mdr_out(mdr_o[g]),
                .busy(busy[g]), .done(done[g]), .err(err[g])
            );
        end
    endgenerate

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] model [NI][DEPTH];

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] data;
        bit          fwd;
        bit          poke;
        logic [15:0] exp_mdr;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic check_reset_state(input int k);
        chk("rst_mar", k, 32'(mar_o[k]), 0);
        chk("rst_mdr", k, 32'(mdr_o[k]), 0);
        chk("rst_busy", k, 32'(busy[k]), 0);
        chk("rst_done", k, 32'(done[k]), 0);
        chk("rst_err", k, 32'(err[k]), 0);
        chk("rst_boot_done", k, 32'(bdone[k]), (be_of(k) == 0) ? 1 : 0);
    endtask

    task automatic boot(input int k, input logic [15:0] base, input bit probe);
        for (int i = 0; i < DEPTH; i++) begin
            bv[k] = 1'b1;
            bd[k] = base + 16'(i);
            if (probe && i == 10) rd[k] = 1'b1;
            tick();
            rd[k] = 1'b0;
            if (probe && i == 10) begin
                chk("boot_rd_ignored_busy", k, 32'(busy[k]), 0);
                chk("boot_no_done", k, 32'(done[k]), 0);
            end
            if (i >= DEPTH - 2) chk("boot_done_edge", k, 32'(bdone[k]), (i == DEPTH - 1) ? 1 : 0);
            model[k][i] = base + 16'(i);
        end
        bv[k] = 1'b0;
        tick();
        chk("boot_idle_busy", k, 32'(busy[k]), 0);
    endtask

    task automatic access(input int k, input bit w, input logic [4:0] addr, input logic [15:0] data,
                          input bit fwd, input bit poke, input logic [15:0] exp_mdr, input bit exp_err);
        int n;
        ldm[k] = 1'b1;
        mar_i[k] = addr;
        if (w) begin
            ldd[k] = 1'b1;
            mdin[k] = data;
        end
        if (!fwd) begin
            tick();
            ldm[k] = 1'b0;
            ldd[k] = 1'b0;
            chk("mar_load", k, 32'(mar_o[k]), 32'(addr));
        end
        rd[k] = !w;
        wr[k] = w;
        tick();
        ldm[k] = 1'b0;
        ldd[k] = 1'b0;
        rd[k]  = 1'b0;
        wr[k]  = 1'b0;
        n = 0;
        while (busy[k] && n < 40) begin
            n++;
            if (poke && n == 1) begin
                ldd[k] = 1'b1;
                mdin[k] = 16'h1234;
                ldm[k] = 1'b1;
                mar_i[k] = 5'd0;
            end
            tick();
            ldd[k] = 1'b0;
            ldm[k] = 1'b0;
        end
        chk("busy_cycles", k, 32'(n), 32'(wc_of(k) + 1));
        chk("done_pulse", k, 32'(done[k]), 1);
        chk("err_flag", k, 32'(err[k]), 32'(exp_err));
        chk("mdr_value", k, 32'(mdr_o[k]), 32'(exp_mdr));
        chk("mar_kept", k, 32'(mar_o[k]), 32'(addr));
        if (w && addr < DEPTH) model[k][addr] = data;
        tick();
        chk("done_one_cycle", k, 32'(done[k]), 0);
        chk("err_one_cycle", k, 32'(err[k]), 0);
    endtask

    task automatic reset_mid_write(input int k);
        ldm[k] = 1'b1;
        mar_i[k] = 5'd2;
        ldd[k] = 1'b1;
        mdin[k] = 16'h5555;
        wr[k] = 1'b1;
        tick();
        ldm[k] = 1'b0;
        ldd[k] = 1'b0;
        wr[k] = 1'b0;
        chk("midwr_busy1", k, 32'(busy[k]), 1);
        tick();
        chk("midwr_busy2", k, 32'(busy[k]), 1);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
        chk("midwr_busy", k, 32'(busy[k]), 0);
        chk("midwr_done", k, 32'(done[k]), 0);
        chk("midwr_mar", k, 32'(mar_o[k]), 0);
        chk("midwr_mdr", k, 32'(mdr_o[k]), 0);
        chk("midwr_boot_done", k, 32'(bdone[k]), (be_of(k) == 0) ? 1 : 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midwr_no_late_done", k, 32'(done[k] | busy[k]), 0);
        end
    endtask

    initial begin
        logic [4:0]  ra;
        logic [15:0] rdat;
        bit          rw;
        bit          rf;

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; bv[k] = 1'b0; ldm[k] = 1'b0; ldd[k] = 1'b0;
            rd[k] = 1'b0; wr[k] = 1'b0; bd[k] = '0; mdin[k] = '0; mar_i[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            check_reset_state(k);
            rst[k] = 1'b0;
        end

        // Boot with a read request poked mid-stream, then the vector table
        tbl[0] = '{1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h1003, 1'b0};
        tbl[1] = '{1'b1, 5'd5,  16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 1'b0};
        tbl[2] = '{1'b0, 5'd5,  16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[3] = '{1'b0, 5'd25, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{1'b1, 5'd25, 16'hAAAA, 1'b0, 1'b0, 16'hAAAA, 1'b1};
        tbl[5] = '{1'b0, 5'd7,  16'h0000, 1'b1, 1'b0, 16'h1007, 1'b0};
        tbl[6] = '{1'b1, 5'd19, 16'h0F0F, 1'b1, 1'b0, 16'h0F0F, 1'b0};
        tbl[7] = '{1'b0, 5'd19, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0};
        boot(0, 16'h1000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            access(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].fwd, tbl[i].poke,
                   tbl[i].exp_mdr, tbl[i].exp_err);
        end

        // Conflicting requests: err pulse, no access, MDR untouched
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        tick();
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        chk("both_done", 0, 32'(done[0]), 1);
        chk("both_err", 0, 32'(err[0]), 1);
        chk("both_busy", 0, 32'(busy[0]), 0);
        chk("both_mdr", 0, 32'(mdr_o[0]), 32'h0F0F);
        tick();
        chk("both_done_clear", 0, 32'(done[0] | busy[0]), 0);

        // Randomized accesses against the array model, then full readback
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rf   = 1'($urandom_range(0, 1));
            ra   = 5'($urandom_range(0, 23));
            rdat = 16'($urandom);
            access(0, rw, ra, rdat, rf, 1'b0,
                   rw ? rdat : ((ra < DEPTH) ? model[0][ra] : 16'h0000), ra >= DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            access(0, 1'b0, 5'(a), 16'h0, 1'b0, 1'b0, model[0][a], 1'b0);
        end

        // No-boot, zero-wait: back-to-back reads with rd_mem held high
        chk("noboot_boot_done", 1, 32'(bdone[1]), 1);
        access(1, 1'b1, 5'd0, 16'h00A0, 1'b1, 1'b0, 16'h00A0, 1'b0);
        access(1, 1'b1, 5'd1, 16'h00A1, 1'b0, 1'b0, 16'h00A1, 1'b0);
        ldm[1] = 1'b1;
        mar_i[1] = 5'd0;
        tick();
        ldm[1] = 1'b0;
        rd[1] = 1'b1;
        tick();
        chk("b2b_busy_a", 1, 32'(busy[1]), 1);
        chk("b2b_done_a0", 1, 32'(done[1]), 0);
        tick();
        chk("b2b_busy_a_fall", 1, 32'(busy[1]), 0);
        chk("b2b_done_a", 1, 32'(done[1]), 1);
        chk("b2b_mdr_a", 1, 32'(mdr_o[1]), 32'h00A0);
        ldm[1] = 1'b1;
        mar_i[1] = 5'd1;
        tick();
        ldm[1] = 1'b0;
        rd[1] = 1'b0;
        chk("b2b_busy_b", 1, 32'(busy[1]), 1);
        chk("b2b_done_b0", 1, 32'(done[1]), 0);
        chk("b2b_mar_b", 1, 32'(mar_o[1]), 1);
        tick();
        chk("b2b_busy_b_fall", 1, 32'(busy[1]), 0);
        chk("b2b_done_b", 1, 32'(done[1]), 1);
        chk("b2b_mdr_b", 1, 32'(mdr_o[1]), 32'h00A1);
        tick();
        chk("b2b_quiet", 1, 32'(done[1] | busy[1]), 0);

        // Reset in the middle of a wait-stated write
        access(3, 1'b1, 5'd2, 16'h1111, 1'b0, 1'b0, 16'h1111, 1'b0);
        reset_mid_write(3);
        access(3, 1'b0, 5'd2, 16'h0, 1'b0, 1'b0, 16'h1111, 1'b0);
        boot(2, 16'h2000, 1'b0);
        reset_mid_write(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
